// File: rtl/mem_responder_pkg.sv
// Shared widths and sizing for the single-outstanding memory responder.
package mem_responder_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int THREAD_ID_WIDTH = 4;
  localparam int MEM_DEPTH       = 16;
  localparam int CNT_WIDTH       = 4;

  // Index width that stays legal even for a single-word memory.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word storage: synchronous write port, combinational read port, cleared by reset.
module mem_array #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array sits in the async reset domain because every word must read 0 after reset; this forces flops, not RAM macros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder with fixed access latency and range checking.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  input  logic [THREAD_ID_WIDTH-1:0] req_tag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic [THREAD_ID_WIDTH-1:0] rsp_tag,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int IDX_W = idx_width(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                     state_q, state_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       we_q, we_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [THREAD_ID_WIDTH-1:0] tag_q, tag_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic                       err_q, err_d;

  logic                  in_range;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Range check runs on the full address so high addresses never alias a valid word.
  assign in_range = (32'(addr_q) < 32'(DEPTH));

  mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk    (clk),
    .rst_n  (reset),
    .we_i   (mem_we),
    .waddr_i(addr_q[IDX_W-1:0]),
    .wdata_i(wdata_q),
    .raddr_i(addr_q[IDX_W-1:0]),
    .rdata_o(mem_rdata)
  );

  // NOTE: every variable driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tag_d   = tag_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          tag_d   = req_tag;
          cnt_d   = CNT_WIDTH'(LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          mem_we  = we_q && in_range;
          rdata_d = (!we_q && in_range) ? mem_rdata : '0;
          err_d   = !in_range;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tag_q   <= tag_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_tag   = tag_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL expose these parameters, one per line: name, default, meaning.
- DATA_WIDTH, `DATA_WIDTH (16), data word width.
- ADDR_WIDTH, 8, request address width (matches the 8-bit instruction immediate).
- DEPTH, 16, number of data words held.
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL expose these ports, one per line: name, direction, width, meaning.
- clk, in, 1, rising-edge clock.
- reset, in, 1, asynchronous active-low reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, block can accept a request.
- req_we, in, 1, 1 = store, 0 = load.
- req_addr, in, ADDR_WIDTH, word address.
- req_wdata, in, DATA_WIDTH, store data.
- req_tag, in, `THREAD_ID_WIDTH, issuing thread ID.
- rsp_valid, out, 1, response present.
- rsp_ready, in, 1, requester accepts the response.
- rsp_rdata, out, DATA_WIDTH, load data (0 for stores and errors).
- rsp_tag, out, `THREAD_ID_WIDTH, echo of req_tag.
- rsp_err, out, 1, address was out of range.
- busy, out, 1, high whenever state is not IDLE.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-005 req_ready SHALL equal (state == IDLE); only one request is outstanding at a time.
REQ-006 On an edge where req_valid && req_ready, the block SHALL latch we, addr, wdata and tag, load the latency counter with LATENCY-1, and go to ACCESS.
REQ-007 In ACCESS, the counter SHALL decrement each cycle; on the edge where the counter is 0 the block SHALL perform the access and go to RESP.
- Consequence: rsp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-008 Load access: rsp_rdata SHALL capture mem[addr] at the access edge.
REQ-009 Store access: mem[addr] SHALL take wdata at the access edge, and rsp_rdata SHALL be 0.
REQ-010 If addr >= DEPTH, the block SHALL set rsp_err=1 and rsp_rdata=0, and SHALL leave memory unmodified.
- Otherwise rsp_err SHALL be 0.
REQ-011 In RESP, rsp_valid SHALL be 1.
- rsp_rdata, rsp_tag and rsp_err SHALL hold stable until rsp_ready is sampled high.
- On that edge the block SHALL return to IDLE.
REQ-012 A new request SHALL NOT be accepted in the same cycle as a response handshake; the earliest next acceptance is the cycle after.
REQ-013 Back-to-back requests to the same address SHALL be strictly ordered: a load following a store observes the stored value.
REQ-014 Request inputs SHALL be ignored outside IDLE.
REQ-015 The addr index SHALL use only the low clog2(DEPTH) bits, after the range check.
- Out-of-range addresses SHALL never alias onto a valid word.

Reset
REQ-016 While reset is low, the outputs SHALL be:
- state = IDLE, req_ready = 1, rsp_valid = 0, busy = 0.
- rsp_rdata = 0, rsp_tag = 0, rsp_err = 0, counter = 0.
REQ-017 Reset SHALL clear every mem word to 0.
REQ-018 Reset asserted mid-operation (ACCESS or RESP) SHALL abandon the transaction.
- Any pending store SHALL NOT be written.
- No response SHALL be produced after reset releases.
REQ-019 The first request SHALL be acceptable on the first rising edge after reset deasserts.

Structure
REQ-020 definitions.vh SHALL hold `DATA_WIDTH, `THREAD_ID_WIDTH and a new `MEM_DEPTH; state encodings SHALL be local parameters of the block.
REQ-021 The storage array SHALL be one sub-module, mem_array, with a synchronous write port and a combinational read port.
- The FSM, counter and handshake SHALL stay in mem_responder.

Verification
REQ-022 Load after reset, LATENCY=2:
- Stimulus: load addr=3, tag=1, rsp_ready=1.
- Response: rsp_valid exactly 2 cycles after acceptance, rdata=0x0000, tag=1, err=0.
REQ-023 Store then load:
- Stimulus: store addr=5, wdata=0xBEEF, tag=2; then load addr=5, tag=3.
- Response: store gives rdata=0, err=0; load gives rdata=0xBEEF, tag=3.
REQ-024 Out-of-range store:
- Stimulus: store addr=16, wdata=0x1234; then load addr=0.
- Response: store gives err=1, rdata=0; load gives rdata=0x0000 (no aliasing).
REQ-025 Response backpressure:
- Stimulus: hold rsp_ready=0 for 5 cycles after rsp_valid.
- Response: rsp_* stable, req_ready=0 throughout; one edge after rsp_ready=1, state is IDLE and req_ready=1.
REQ-026 Reset mid-ACCESS:
- Stimulus: store addr=7, wdata=0xAAAA; assert reset 1 cycle after acceptance; release; then load addr=7.
- Response: no rsp_valid before the load; load returns rdata=0x0000.
REQ-027 LATENCY=1 throughput:
- Stimulus: 4 back-to-back loads with rsp_ready tied to 1.
- Response: acceptances are exactly 3 cycles apart (accept, access/RESP, handshake).
